// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } skid_state_t;

  // Reset payload bit, replicated to the payload width by users
  localparam logic RST_PAYLOAD_BIT = 1'b0;

endpackage

// File: rtl/pipe_data_reg.sv
// Load-enable payload register with synchronous active-high reset to the reset payload.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= {W{RST_PAYLOAD_BIT}};
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage with a 2-entry skid buffer; ready is registered, never combinational.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned W  = 32
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  parameter int unsigned CW = 16
`endif
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [W-1:0]  in_data_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [W-1:0]  out_data_o
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [CW-1:0] stall_cnt_o
`endif
);

  skid_state_t  state_q, state_d;
  logic         in_ready_q, out_valid_q;
  logic         in_fire_c, out_fire_c;
  logic         main_en_c, skid_en_c, main_from_skid_c;
  logic [W-1:0] main_d, skid_q;

  assign in_fire_c  = in_valid_i & in_ready_q;
  assign out_fire_c = out_valid_q & out_ready_i;

  // Next state and data-register load control
  always_comb begin
    state_d          = state_q;
    main_en_c        = 1'b0;
    skid_en_c        = 1'b0;
    main_from_skid_c = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          state_d   = ONE;
          main_en_c = 1'b1;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          main_en_c = 1'b1;
        end else if (in_fire_c) begin
          state_d   = TWO;
          skid_en_c = 1'b1;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire_c) begin
          state_d          = ONE;
          main_en_c        = 1'b1;
          main_from_skid_c = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush_i) begin
      state_d = EMPTY;
    end
  end

  assign main_d = main_from_skid_c ? skid_q : in_data_i;

  // Handshake flags are registered from the next state so they come straight off flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != EMPTY);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;

  pipe_data_reg #(.W(W)) u_main_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (main_en_c),
    .d_i   (main_d),
    .q_o   (out_data_o)
  );

  pipe_data_reg #(.W(W)) u_skid_reg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (skid_en_c),
    .d_i   (in_data_i),
    .q_o   (skid_q)
  );

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_q;

  // Saturating count of cycles the downstream refuses a valid payload; survives flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (out_valid_q && !out_ready_i && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CW'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: driver queues accepted payloads, monitor checks outputs.
module tb_pipe_skid_stage;
  localparam int unsigned W  = 32;
`ifdef PIPE_SKID_STALL_CNT_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] stall_cnt;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;

  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .W (W)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .CW(CW)
`endif
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data)
`ifdef PIPE_SKID_STALL_CNT_EN
    , .stall_cnt_o (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: apply inputs, record an accepted payload, advance past the edge
  task automatic drive(input logic v, input logic [W-1:0] d, input logic ordy,
                       input logic fl, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    if (fl || r) exp_q.delete();
    else if (v && in_ready) exp_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every downstream transfer must match the oldest expected payload
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL mon_spurious: got %0h expected no output", out_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          n_fail++;
          $display("FAIL mon_order: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_data", out_data, W'(0));
`ifdef PIPE_SKID_STALL_CNT_EN
    chk("rst_stall_cnt", W'(stall_cnt), W'(0));
`endif

    // 2: streaming 1..10 at full rate
    for (int i = 1; i <= 10; i++) begin
      chk("stream_in_ready", W'(in_ready), W'(1));
      drive(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
      chk("stream_out_data", out_data, W'(i));
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("stream_drained", W'(out_valid), W'(0));

    // 3: backpressure A5, B6, C7
    drive(1'b1, W'('hA5), 1'b0, 1'b0, 1'b0);
    chk("bp_a5_out", out_data, W'('hA5));
    drive(1'b1, W'('hB6), 1'b0, 1'b0, 1'b0);
    chk("bp_full_ready", W'(in_ready), W'(0));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'('hC7), 1'b0, 1'b0, 1'b0);
      chk("bp_hold_data", out_data, W'('hA5));
      chk("bp_hold_valid", W'(out_valid), W'(1));
      chk("bp_hold_ready", W'(in_ready), W'(0));
    end
    drive(1'b1, W'('hC7), 1'b1, 1'b0, 1'b0);
    chk("bp_b6_out", out_data, W'('hB6));
    drive(1'b1, W'('hC7), 1'b1, 1'b0, 1'b0);
    chk("bp_c7_out", out_data, W'('hC7));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bp_drained", W'(out_valid), W'(0));

    // 4: flush while full with a valid input
    drive(1'b1, W'(11), 1'b0, 1'b0, 1'b0);
    drive(1'b1, W'(12), 1'b0, 1'b0, 1'b0);
    chk("fl_full", W'(in_ready), W'(0));
    drive(1'b1, W'(13), 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", W'(out_valid), W'(0));
    chk("fl_in_ready", W'(in_ready), W'(1));
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fl_stays_empty", W'(out_valid), W'(0));

    // 5: reset together with flush while full
    drive(1'b1, W'(21), 1'b0, 1'b0, 1'b0);
    drive(1'b1, W'(22), 1'b0, 1'b0, 1'b0);
    drive(1'b1, W'(23), 1'b0, 1'b1, 1'b1);
    chk("rf_out_valid", W'(out_valid), W'(0));
    chk("rf_out_data", out_data, W'(0));
    chk("rf_in_ready", W'(in_ready), W'(1));
    drive(1'b1, W'('h33), 1'b1, 1'b0, 1'b0);
    chk("rf_next_word", out_data, W'('h33));
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("rf_drained", W'(out_valid), W'(0));

`ifdef PIPE_SKID_STALL_CNT_EN
    // 6: stall counter saturation, flush retention, reset clear
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, W'('h44), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (i == 5) chk("cnt_5", W'(stall_cnt), W'(5));
    end
    chk("cnt_sat", W'(stall_cnt), W'(15));
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("cnt_flush", W'(stall_cnt), W'(15));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("cnt_rst", W'(stall_cnt), W'(0));
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
`endif

    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("sb_empty", W'(exp_q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
